// File: rtl/radix4_pkg.sv
// Shared types and sizing helpers for the radix-4 Booth multiplier.
package radix4_pkg;

   typedef struct packed {
      logic neg;
      logic two;
      logic one;
   } booth_digit_t;

   localparam booth_digit_t DIGIT_ZERO = '{neg: 1'b0, two: 1'b0, one: 1'b0};

   function automatic int unsigned npp(input int unsigned width);
      return width / 2 + 1;
   endfunction

   function automatic int unsigned row_width(input int unsigned width);
      return 2 * width;
   endfunction

   // Overlapping triplet {x[2i+1], x[2i], x[2i-1]} -> digit in {-2..+2}; 111 is -0, kept as zero.
   function automatic booth_digit_t booth_enc(input logic [2:0] trip);
      booth_digit_t d;
      d = DIGIT_ZERO;
      case (trip)
         3'b001, 3'b010: d.one = 1'b1;
         3'b011:         d.two = 1'b1;
         3'b100: begin
            d.neg = 1'b1;
            d.two = 1'b1;
         end
         3'b101, 3'b110: begin
            d.neg = 1'b1;
            d.one = 1'b1;
         end
         default:        d = DIGIT_ZERO;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/radix4_booth_encoder_p.sv
// Combinational Booth recoder: multiplier + multiplicand -> shifted partial-product rows and carry-ins.
module radix4_booth_encoder_p
   import radix4_pkg::*;
#(
   parameter int unsigned WIDTH = 11
) (
   input  logic [WIDTH-1:0]                                a,
   input  logic [WIDTH-1:0]                                x,
   input  logic                                            signed_mode,
   output logic [npp(WIDTH)-1:0][row_width(WIDTH)-1:0]     rows_c,
   output logic [npp(WIDTH)-1:0]                           cin_c
);

   localparam int unsigned NPP = npp(WIDTH);
   localparam int unsigned RW  = row_width(WIDTH);
   localparam int unsigned XW  = 2 * NPP;
   localparam int unsigned AW  = WIDTH + 2;

   logic          x_ext;
   logic          a_ext;
   logic [XW:0]   x_pad;
   logic [AW-1:0] a_wide;

   assign x_ext  = signed_mode & x[WIDTH-1];
   assign a_ext  = signed_mode & a[WIDTH-1];
   // Bit 0 is the implicit x[-1]=0; the top is extended to an even digit count.
   assign x_pad  = {{(XW - WIDTH){x_ext}}, x, 1'b0};
   assign a_wide = {{2{a_ext}}, a};

   for (genvar i = 0; i < NPP; i++) begin : g_row
      booth_digit_t  dig;
      logic [AW-1:0] mag;
      logic [RW-1:0] row;

      assign dig = booth_enc(x_pad[2*i +: 3]);
      // One's complement here; the +1 travels as cin_c[i] at the row LSB.
      assign mag = (dig.one ? a_wide : (dig.two ? {a_wide[AW-2:0], 1'b0} : '0)) ^ {AW{dig.neg}};
      assign row = {{(RW - AW){mag[AW-1]}}, mag};
      assign rows_c[i] = row << (2 * i);
      assign cin_c[i]  = dig.neg;
   end

endmodule

// File: rtl/radix4_mult_pipe.sv
// Pipelined radix-4 Booth multiplier, signed/unsigned per beat, valid/ready with full backpressure.
module radix4_mult_pipe
   import radix4_pkg::*;
#(
   parameter int unsigned WIDTH = 11,
   parameter int unsigned TAG_W = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 signed_in,
   input  logic [WIDTH-1:0]     a_in,
   input  logic [WIDTH-1:0]     x_in,
   input  logic [TAG_W-1:0]     tag_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   p_out,
   output logic [TAG_W-1:0]     tag_out
);

   localparam int unsigned NPP = npp(WIDTH);
   localparam int unsigned RW  = row_width(WIDTH);

   logic                   advance;

   logic                   op_v;
   logic                   op_sgn;
   logic [WIDTH-1:0]       op_a;
   logic [WIDTH-1:0]       op_x;
   logic [TAG_W-1:0]       op_tag;

   logic [NPP-1:0][RW-1:0] rows_c;
   logic [NPP-1:0]         cin_c;
   logic [2*NPP-1:0]       cin_il;

   logic                   pp_v;
   logic [NPP-1:0][RW-1:0] pp_rows;
   logic [RW-1:0]          pp_cin;
   logic [TAG_W-1:0]       pp_tag;

   logic                   cs_v;
   logic [RW-1:0]          cs_sum;
   logic [RW-1:0]          cs_car;
   logic [TAG_W-1:0]       cs_tag;

   logic [RW-1:0]          sum_c;
   logic [RW-1:0]          car_c;

   // Whole pipe moves in lockstep; only a held output can stall it.
   assign advance  = ~out_valid | out_ready;
   assign in_ready = advance & rst_n;

   radix4_booth_encoder_p #(.WIDTH(WIDTH)) u_enc (
      .a           (op_a),
      .x           (op_x),
      .signed_mode (op_sgn),
      .rows_c      (rows_c),
      .cin_c       (cin_c)
   );

   // Negation carry-ins become one extra sparse row at even bit positions.
   for (genvar i = 0; i < NPP; i++) begin : g_cin
      assign cin_il[2*i]   = cin_c[i];
      assign cin_il[2*i+1] = 1'b0;
   end

   // Carry-save chain: NPP rows plus the carry-in row down to sum/carry.
   for (genvar i = 0; i < NPP; i++) begin : g_csa
      logic [RW-1:0] s;
      logic [RW-1:0] c;
      if (i == 0) begin : g_init
         assign s = pp_cin;
         assign c = pp_rows[0];
      end else begin : g_step
         assign s = g_csa[i-1].s ^ g_csa[i-1].c ^ pp_rows[i];
         assign c = ((g_csa[i-1].s & g_csa[i-1].c) |
                     (g_csa[i-1].s & pp_rows[i])   |
                     (g_csa[i-1].c & pp_rows[i])) << 1;
      end
   end

   assign sum_c = g_csa[NPP-1].s;
   assign car_c = g_csa[NPP-1].c;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_v      <= 1'b0;
         pp_v      <= 1'b0;
         cs_v      <= 1'b0;
         out_valid <= 1'b0;
         p_out     <= '0;
         tag_out   <= '0;
      end else if (advance) begin
         op_v      <= in_valid;
         pp_v      <= op_v;
         cs_v      <= pp_v;
         out_valid <= cs_v;
         if (in_valid) begin
            op_a   <= a_in;
            op_x   <= x_in;
            op_sgn <= signed_in;
            op_tag <= tag_in;
         end
         if (op_v) begin
            pp_rows <= rows_c;
            pp_cin  <= RW'(cin_il);
            pp_tag  <= op_tag;
         end
         if (pp_v) begin
            cs_sum <= sum_c;
            cs_car <= car_c;
            cs_tag <= pp_tag;
         end
         if (cs_v) begin
            p_out   <= cs_sum + cs_car;
            tag_out <= cs_tag;
         end
      end
   end

endmodule

// File: tb/tb_radix4_mult_pipe.sv
// Scoreboard bench for radix4_mult_pipe: directed corners, stall, reset flush and random traffic.
module tb_radix4_mult_pipe;

   localparam int unsigned W  = 11;
   localparam int unsigned TW = 4;
   localparam int unsigned PW = 2 * W;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic          signed_in;
   logic [W-1:0]  a_in;
   logic [W-1:0]  x_in;
   logic [TW-1:0] tag_in;
   logic          out_valid;
   logic          out_ready;
   logic [PW-1:0] p_out;
   logic [TW-1:0] tag_out;

   typedef struct {
      logic [PW-1:0] p;
      logic [TW-1:0] t;
      int            acc;
      bit            lat;
   } exp_t;

   exp_t q[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc         = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   radix4_mult_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .signed_in (signed_in),
      .a_in      (a_in),
      .x_in      (x_in),
      .tag_in    (tag_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p_out     (p_out),
      .tag_out   (tag_out)
   );

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // Reference: interpret operands per mode as integers, multiply, keep 2W bits.
   function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] x, input bit s);
      longint av, xv, prod;
      av = longint'(a);
      xv = longint'(x);
      if (s && a[W-1]) av = av - (longint'(1) << W);
      if (s && x[W-1]) xv = xv - (longint'(1) << W);
      prod = av * xv;
      return PW'(prod);
   endfunction

   function automatic logic [W-1:0] pick();
      logic [W-1:0] v;
      case ($urandom % 8)
         0:       v = '0;
         1:       v = '1;
         2:       v = {1'b1, {(W-1){1'b0}}};
         3:       v = W'(1);
         default: v = W'($urandom);
      endcase
      return v;
   endfunction

   task automatic drive(input bit v, input logic [W-1:0] a, input logic [W-1:0] x, input bit s,
                        input logic [TW-1:0] t, input bit ordy, input logic [PW-1:0] exp_p,
                        input bit lat, output bit acc);
      @(negedge clk);
      out_ready = ordy;
      in_valid  = v;
      a_in      = a;
      x_in      = x;
      signed_in = s;
      tag_in    = t;
      #1;
      acc = v && in_ready && rst_n;
      if (acc) q.push_back('{p: exp_p, t: t, acc: cyc + 1, lat: lat});
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] x, input bit s,
                       input logic [TW-1:0] t, input logic [PW-1:0] exp_p, input bit lat);
      bit acc;
      acc = 1'b0;
      for (int k = 0; k < 50 && !acc; k++) drive(1'b1, a, x, s, t, 1'b1, exp_p, lat, acc);
      check("send_accept", 64'(acc), 64'd1);
   endtask

   task automatic idle(input int n);
      bit acc;
      repeat (n) drive(1'b0, '0, '0, 1'b0, '0, 1'b1, '0, 1'b0, acc);
   endtask

   // Monitor: pops on every output transfer and checks hold stability during stalls.
   initial begin
      exp_t          e;
      bit            hold_prev;
      logic [PW-1:0] hold_p;
      logic [TW-1:0] hold_t;
      hold_prev = 1'b0;
      hold_p    = '0;
      hold_t    = '0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            hold_prev = 1'b0;
            continue;
         end
         if (hold_prev) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_p", 64'(p_out), 64'(hold_p));
            check("hold_tag", 64'(tag_out), 64'(hold_t));
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("out_without_beat", 64'(out_valid), 64'd0);
            end else begin
               e = q.pop_front();
               check("product", 64'(p_out), 64'(e.p));
               check("tag", 64'(tag_out), 64'(e.t));
               if (e.lat) check("latency", 64'(cyc - e.acc), 64'd3);
            end
         end
         hold_prev = out_valid && !out_ready;
         hold_p    = p_out;
         hold_t    = tag_out;
      end
   end

   initial begin
      bit           acc;
      bit           ordy;
      bit           s;
      bit           v;
      int           nt;
      int           k;
      logic [W-1:0] a;
      logic [W-1:0] x;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      signed_in = 1'b0;
      a_in      = '0;
      x_in      = '0;
      tag_in    = '0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_p_out", 64'(p_out), 64'd0);
      check("rst_tag_out", 64'(tag_out), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      rst_n = 1'b1;
      idle(1);

      // Directed corners with fixed expected products.
      send(11'h7FF, 11'h7FF, 1'b0, 4'h5, 22'h3FF001, 1'b1);
      send(11'h400, 11'h400, 1'b1, 4'h6, 22'h100000, 1'b1);
      send(11'h400, 11'h3FF, 1'b1, 4'h7, 22'h300400, 1'b1);
      send(11'h000, 11'h7FF, 1'b1, 4'h8, 22'h000000, 1'b1);
      idle(4);

      // Back-to-back alternating mode.
      send(11'h7FF, 11'h7FF, 1'b0, 4'h1, 22'h3FF001, 1'b1);
      send(11'h7FF, 11'h7FF, 1'b1, 4'h2, 22'h000001, 1'b1);
      send(11'h7FF, 11'h7FF, 1'b0, 4'h3, 22'h3FF001, 1'b1);
      send(11'h7FF, 11'h7FF, 1'b1, 4'h4, 22'h000001, 1'b1);
      idle(4);

      // Tag stream 0..7 with a 5-cycle output stall in the middle.
      nt = 0;
      k  = 0;
      while (nt < 8 && k < 100) begin
         ordy = !(k >= 4 && k < 9);
         a    = W'(nt * 200 + 3);
         x    = W'(2047 - nt * 150);
         s    = nt[0];
         drive(1'b1, a, x, s, TW'(nt), ordy, ref_mul(a, x, s), 1'b0, acc);
         if (!ordy) check("in_ready_stall", 64'(in_ready), 64'd0);
         if (acc) nt++;
         k++;
      end
      check("stream_done", 64'(nt), 64'd8);
      idle(6);

      // Reset with three beats in flight.
      send(11'h123, 11'h456, 1'b0, 4'h9, ref_mul(11'h123, 11'h456, 1'b0), 1'b0);
      send(11'h7FF, 11'h400, 1'b1, 4'hA, ref_mul(11'h7FF, 11'h400, 1'b1), 1'b0);
      send(11'h2AA, 11'h555, 1'b1, 4'hB, ref_mul(11'h2AA, 11'h555, 1'b1), 1'b0);
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      check("in_ready_in_rst", 64'(in_ready), 64'd0);
      @(negedge clk);
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_p_out", 64'(p_out), 64'd0);
      check("midrst_tag_out", 64'(tag_out), 64'd0);
      q.delete();
      rst_n = 1'b1;
      idle(6);
      send(11'h0F3, 11'h6E1, 1'b1, 4'hC, ref_mul(11'h0F3, 11'h6E1, 1'b1), 1'b1);
      idle(5);

      // Random traffic with random mode, in_valid and out_ready.
      for (int n = 0; n < 3000; n++) begin
         a    = pick();
         x    = pick();
         s    = 1'($urandom % 2);
         v    = ($urandom % 4) != 0;
         ordy = ($urandom % 4) != 0;
         drive(v, a, x, s, TW'(n), ordy, ref_mul(a, x, s), 1'b0, acc);
      end

      k = 0;
      while (q.size() != 0 && k < 200) begin
         idle(1);
         k++;
      end
      check("drain_empty", 64'(q.size()), 64'd0);
      idle(3);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
